// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter in front of one shared memory port
//
// Purpose: grants a single shared memory port to an instruction-fetch
// requester (IF) or a data requester (D). D has priority, but after STREAK
// consecutive D grants while a fetch is waiting, the fetch is served. An access
// that sees no m_ready within TIMEOUT cycles is closed with err and zero data.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   if_req/if_addr               fetch request and address
//   if_rdata/if_valid            fetched word (registered), one-cycle complete pulse
//   d_req/d_we/d_addr/d_wdata    data request, store flag, address, store data
//   d_rdata/d_valid              load data (registered), one-cycle complete pulse
//   m_req/m_we/m_addr/m_wdata    shared-memory request side (addr/we/wdata latched on grant)
//   m_ready/m_rdata              memory completion and read data
//   stall_if/stall_mem           combinational pipeline stall requests
//   err                          timeout flag, high with the valid pulse
//   busy                         high whenever the arbiter is not idle
module mem_port_arbiter #(
  parameter int STREAK  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ready,
  input  logic [31:0] m_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        err,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [2:0]    STREAK_V = 3'(STREAK);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACC_IF = 2'd1,
    S_ACC_D  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_owner_d;
  logic [2:0]      r_streak;
  logic [TW-1:0]   r_tmo;
  logic            r_err;
  logic            w_grant_if;
  logic            w_grant_d;
  logic            w_timeout;
  logic            w_acc;
  logic [31:0]     w_cap;

  assign w_acc = (r_state == S_ACC_IF) || (r_state == S_ACC_D);
  // A timed-out access returns zero data instead of whatever is on m_rdata.
  assign w_cap = m_ready ? m_rdata : 32'h0;

  always_comb begin
    w_next     = r_state;
    w_grant_if = 1'b0;
    w_grant_d  = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // D wins unless the fetch has already been passed over STREAK times.
        if (d_req && !(if_req && (r_streak == STREAK_V))) begin
          w_grant_d = 1'b1;
          w_next    = S_ACC_D;
        end else if (if_req) begin
          w_grant_if = 1'b1;
          w_next     = S_ACC_IF;
        end
      end
      S_ACC_IF, S_ACC_D: begin
        if (m_ready) begin
          w_next = S_DONE;
        end else if (r_tmo == TMO_LAST) begin
          // This is the TIMEOUT-th cycle without m_ready.
          w_timeout = 1'b1;
          w_next    = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_owner_d <= 1'b0;
      r_streak  <= 3'd0;
      r_tmo     <= '0;
      r_err     <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= 32'h0;
      m_wdata   <= 32'h0;
      if_rdata  <= 32'h0;
      d_rdata   <= 32'h0;
    end else begin
      r_state <= w_next;
      // err lives exactly for the DONE cycle that follows a timeout.
      r_err   <= w_timeout;
      if (w_grant_d) begin
        m_addr    <= d_addr;
        m_we      <= d_we;
        m_wdata   <= d_wdata;
        r_owner_d <= 1'b1;
        r_tmo     <= '0;
        if (if_req) begin
          if (r_streak != STREAK_V) r_streak <= r_streak + 3'd1;
        end else begin
          r_streak <= 3'd0;
        end
      end
      if (w_grant_if) begin
        m_addr    <= if_addr;
        m_we      <= 1'b0;
        m_wdata   <= 32'h0;
        r_owner_d <= 1'b0;
        r_tmo     <= '0;
        r_streak  <= 3'd0;
      end
      if (w_acc && !m_ready) r_tmo <= r_tmo + TMO_ONE;
      if (w_acc && (m_ready || w_timeout)) begin
        if (r_state == S_ACC_D) d_rdata  <= m_we ? 32'h0 : w_cap;
        else                    if_rdata <= w_cap;
      end
    end
  end

  assign m_req     = w_acc;
  assign if_valid  = (r_state == S_DONE) && !r_owner_d;
  assign d_valid   = (r_state == S_DONE) && r_owner_d;
  assign err       = r_err;
  assign busy      = (r_state != S_IDLE);
  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = d_req & ~d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int STREAK  = 4;
  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic        err;
  logic        busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STREAK(STREAK), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .err(err), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Requester-level model: outstanding requests, their payloads, and the
  // number of D grants that have bypassed a waiting fetch.
  bit          if_pend, d_pend, d_w;
  logic [31:0] if_a, d_a, d_wd;
  int          streak_m;
  logic [31:0] exp_if_rd, exp_d_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_reqs();
    if_req  = if_pend;
    if_addr = if_a;
    d_req   = d_pend;
    d_addr  = d_a;
    d_we    = d_w;
    d_wdata = d_wd;
    m_ready = 1'($urandom_range(0, 1));
    m_rdata = $urandom;
  endtask

  task automatic issue(input int p_if, input int p_d);
    if (!if_pend && ($urandom_range(0, 99) < p_if)) begin
      if_pend = 1; if_a = $urandom;
    end
    if (!d_pend && ($urandom_range(0, 99) < p_d)) begin
      d_pend = 1; d_a = $urandom; d_w = 1'($urandom_range(0, 1)); d_wd = $urandom;
    end
    if (!if_pend && !d_pend) begin
      if_pend = 1; if_a = $urandom;
    end
    drive_reqs();
  endtask

  // Called at the falling edge of an idle cycle with requests already driven.
  // lat = cycles of m_ready low before completion; lat >= TIMEOUT never completes.
  task automatic access(input int lat, input bit drop_owner, input logic [31:0] rd);
    bit          gd, to, rdy, fin, ewe;
    logic [31:0] ea, ewd, exp_rd;
    int          c;
    gd  = d_pend && !(if_pend && streak_m == STREAK);
    ea  = gd ? d_a : if_a;
    ewe = gd ? d_w : 1'b0;
    ewd = gd ? d_wd : 32'h0;
    if (gd) streak_m = if_pend ? ((streak_m >= STREAK) ? STREAK : streak_m + 1) : 0;
    else    streak_m = 0;
    to  = (lat >= TIMEOUT);
    c   = 0;
    fin = 0;
    while (!fin) begin
      @(negedge clk);
      c++;
      check("acc_m_req", m_req, 1);
      check("acc_busy", busy, 1);
      check("acc_m_addr", m_addr, ea);
      check("acc_m_we", m_we, ewe);
      check("acc_m_wdata", m_wdata, ewd);
      if (c == 1) begin
        // Scramble the granted requester's inputs: the latched values must hold.
        if (gd) begin
          d_addr = $urandom; d_wdata = $urandom; d_we = ~d_we;
          if (drop_owner) d_req = 1'b0;
        end else begin
          if_addr = $urandom;
          if (drop_owner) if_req = 1'b0;
        end
      end
      rdy     = !to && (c == lat + 1);
      m_ready = rdy;
      m_rdata = rdy ? rd : $urandom;
      #1;
      check("acc_stall_if", stall_if, if_req);
      check("acc_stall_mem", stall_mem, d_req);
      check("acc_valids", {if_valid, d_valid}, 0);
      fin = rdy || (to && c == TIMEOUT);
    end
    @(negedge clk);
    exp_rd = (to || (gd && ewe)) ? 32'h0 : rd;
    if (gd) exp_d_rd = exp_rd; else exp_if_rd = exp_rd;
    check("done_if_valid", if_valid, !gd);
    check("done_d_valid", d_valid, gd);
    check("done_err", err, to);
    check("done_m_req", m_req, 0);
    check("done_busy", busy, 1);
    check("done_if_rdata", if_rdata, exp_if_rd);
    check("done_d_rdata", d_rdata, exp_d_rd);
    m_ready = 1'($urandom_range(0, 1));
    m_rdata = $urandom;
    #1;
    check("done_stall_if", stall_if, if_req & gd);
    check("done_stall_mem", stall_mem, d_req & !gd);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_m_req", m_req, 0);
    check("idle_valids", {if_valid, d_valid, err}, 0);
    if (gd) d_pend = 0; else if_pend = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    if_pend = 0; d_pend = 0; d_w = 0;
    if_a = 0; d_a = 0; d_wd = 0;
    streak_m = 0; exp_if_rd = 0; exp_d_rd = 0;
    rst = 1'b1;
    drive_reqs();
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_m_req", m_req, 0);
    check("rst_m_we", m_we, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_wdata", m_wdata, 0);
    check("rst_valids", {if_valid, d_valid, err, busy}, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    rst = 1'b0;

    // Fetch only, immediate ready.
    if_pend = 1; if_a = 32'h100; d_pend = 0;
    drive_reqs();
    access(0, 0, 32'h00500093);

    // Simultaneous: D store first, then the waiting fetch.
    if_pend = 1; if_a = $urandom;
    d_pend = 1; d_a = 32'h2000; d_w = 1; d_wd = 32'hDEADBEEF;
    drive_reqs();
    access(1, 0, $urandom);
    drive_reqs();
    access(0, 0, $urandom);

    // Fairness: fetch held while D keeps re-requesting.
    if_pend = 1; if_a = $urandom;
    for (int i = 0; i < 7; i++) begin
      if (!d_pend) begin
        d_pend = 1; d_a = $urandom; d_w = 1'($urandom_range(0, 1)); d_wd = $urandom;
      end
      drive_reqs();
      access($urandom_range(0, 2), 0, $urandom);
    end
    if_pend = 0; d_pend = 0;

    // Delayed ready with address changes after the grant.
    d_pend = 1; d_a = 32'h4444; d_w = 0; d_wd = $urandom;
    drive_reqs();
    access(3, 0, $urandom);

    // Timeout, and the last-cycle completion boundary.
    d_pend = 1; d_a = $urandom; d_w = 0; d_wd = $urandom;
    drive_reqs();
    access(TIMEOUT, 0, $urandom);
    if_pend = 1; if_a = $urandom;
    drive_reqs();
    access(TIMEOUT - 1, 0, $urandom);

    // Reset during a fetch access.
    if_pend = 1; if_a = 32'h300; d_pend = 0;
    drive_reqs();
    @(negedge clk);
    check("pre_rst_m_req", m_req, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_m_req", m_req, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_if_valid", if_valid, 0);
    check("mid_rst_if_rdata", if_rdata, 0);
    @(negedge clk);
    check("post_rst_state", {if_valid, busy, m_req}, 0);
    rst = 1'b0;
    streak_m = 0; exp_if_rd = 0; exp_d_rd = 0;
    access(2, 0, $urandom);

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      issue(60, 60);
      access($urandom_range(0, 4), ($urandom_range(0, 7) == 0), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
